// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program-memory loader.
// This package holds the state encoding, error codes and checksum helper.
package prog_loader_pkg;

   localparam int INSTR_W = 18;
   localparam int BYTE_W  = 8;

   localparam logic [2:0] ERR_NONE    = 3'b000;
   localparam logic [2:0] ERR_CSUM    = 3'b001;
   localparam logic [2:0] ERR_LEN     = 3'b010;
   localparam logic [2:0] ERR_FMT     = 3'b011;
   localparam logic [2:0] ERR_TIMEOUT = 3'b100;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_CNT_HI = 4'd1,
      ST_CNT_LO = 4'd2,
      ST_B0     = 4'd3,
      ST_B1     = 4'd4,
      ST_B2     = 4'd5,
      ST_WRITE  = 4'd6,
      ST_CSUM   = 4'd7,
      ST_DONE   = 4'd8,
      ST_ERROR  = 4'd9
   } loaderState_t;

   // Modulo-256 running checksum step.
   function automatic logic [BYTE_W-1:0] csumAdd(input logic [BYTE_W-1:0] sum,
                                                 input logic [BYTE_W-1:0] data);
      return sum + data;
   endfunction

   function automatic logic isLoading(input loaderState_t st);
      logic res;
      case (st)
         ST_IDLE, ST_DONE, ST_ERROR: res = 1'b0;
         default:                    res = 1'b1;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/prog_loader_timer.sv
// Inter-byte idle timer for the loader.
// It is a clearable, enabled down-counter with a registered expired flag.
module loader_timer #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] count_r;
   logic [CW-1:0] countNext_s;
   logic          expired_r;

   // Next count: reload on clear, otherwise count down to zero and stick there.
   always_comb begin
      countNext_s = count_r;
      if (i_clear) begin
         countNext_s = LOAD_VAL;
      end else if (i_enable && (count_r != {CW{1'b0}})) begin
         countNext_s = count_r - CW'(1);
      end else begin
         countNext_s = count_r;
      end
   end

   // Count and expired-flag registers.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         count_r   <= LOAD_VAL;
         expired_r <= 1'b0;
      end else begin
         count_r   <= countNext_s;
         expired_r <= (countNext_s == {CW{1'b0}});
      end
   end

   assign o_expired = expired_r;

endmodule

// File: rtl/prog_loader.sv
// Program-memory loader: receives a framed byte stream, writes 18-bit words
// into program RAM, checks the checksum and releases the CPU on success.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int MAX_WORDS      = 1024,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [0:7]  i_rxData,
   input  logic        i_rxValid,
   output logic        o_rxReady,
   output logic [0:15] o_memAddr,
   output logic [0:17] o_memData,
   output logic        o_memWE,
   output logic        o_cpuHold,
   output logic        o_busy,
   output logic        o_done,
   output logic [0:2]  o_errCode
);

   loaderState_t  state_r, nextState_s;
   logic [2:0]    errNext_s;
   logic          rxReady_s, accept_s, startSession_s, expired_s, timerClr_s;
   logic [7:0]    sumNext_s;
   logic [15:0]   count16_s;

   logic [7:0]    checksum_r, countHi_r;
   logic [15:0]   wordCount_r, memAddr_r;
   logic [0:1]    instrHi_r;
   logic [0:7]    instrMid_r;
   logic [0:17]   memData_r;
   logic          memWE_r, busy_r, done_r, cpuHold_r;
   logic [2:0]    errCode_r;

   loader_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_clear  (timerClr_s),
      .i_enable (rxReady_s),
      .o_expired(expired_s)
   );

   // Next-state logic and handshake decode.
   always_comb begin
      nextState_s    = state_r;
      errNext_s      = ERR_NONE;
      rxReady_s      = 1'b0;
      startSession_s = 1'b0;
      case (state_r)
         ST_CNT_HI, ST_CNT_LO, ST_B0, ST_B1, ST_B2, ST_CSUM: rxReady_s = 1'b1;
         default:                                          rxReady_s = 1'b0;
      endcase
      accept_s   = rxReady_s & i_rxValid;
      timerClr_s = accept_s | ~isLoading(state_r);
      sumNext_s  = csumAdd(checksum_r, i_rxData);
      count16_s  = {countHi_r, i_rxData};

      case (state_r)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (i_start) begin
               startSession_s = 1'b1;
               nextState_s    = ST_CNT_HI;
            end else begin
               nextState_s = state_r;
            end
         end
         ST_WRITE: begin
            if (memAddr_r == (wordCount_r - 16'd1)) begin
               nextState_s = ST_CSUM;
            end else begin
               nextState_s = ST_B0;
            end
         end
         default: begin
            // Byte-receiving states: an accept takes priority over timeout.
            if (accept_s) begin
               case (state_r)
                  ST_CNT_HI: nextState_s = ST_CNT_LO;
                  ST_CNT_LO: begin
                     if (count16_s > 16'(MAX_WORDS)) begin
                        nextState_s = ST_ERROR;
                        errNext_s   = ERR_LEN;
                     end else if (count16_s == 16'd0) begin
                        nextState_s = ST_CSUM;
                     end else begin
                        nextState_s = ST_B0;
                     end
                  end
                  ST_B0: begin
                     if (i_rxData[0:5] != 6'd0) begin
                        nextState_s = ST_ERROR;
                        errNext_s   = ERR_FMT;
                     end else begin
                        nextState_s = ST_B1;
                     end
                  end
                  ST_B1: nextState_s = ST_B2;
                  ST_B2: nextState_s = ST_WRITE;
                  ST_CSUM: begin
                     if (sumNext_s == 8'd0) begin
                        nextState_s = ST_DONE;
                     end else begin
                        nextState_s = ST_ERROR;
                        errNext_s   = ERR_CSUM;
                     end
                  end
                  default: nextState_s = ST_IDLE;
               endcase
            end else if (expired_s) begin
               nextState_s = ST_ERROR;
               errNext_s   = ERR_TIMEOUT;
            end else begin
               nextState_s = state_r;
            end
         end
      endcase
   end

   // State register.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= nextState_s;
      end
   end

   // Datapath and registered status outputs.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         checksum_r  <= 8'd0;
         countHi_r   <= 8'd0;
         wordCount_r <= 16'd0;
         memAddr_r   <= 16'd0;
         instrHi_r   <= 2'd0;
         instrMid_r  <= 8'd0;
         memData_r   <= 18'd0;
         memWE_r     <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         cpuHold_r   <= 1'b1;
         errCode_r   <= ERR_NONE;
      end else begin
         memWE_r   <= (nextState_s == ST_WRITE);
         busy_r    <= isLoading(nextState_s);
         done_r    <= (nextState_s == ST_DONE);
         cpuHold_r <= (nextState_s != ST_DONE);
         if (startSession_s) begin
            memAddr_r  <= 16'd0;
            checksum_r <= 8'd0;
            errCode_r  <= ERR_NONE;
         end else begin
            if (accept_s) begin
               checksum_r <= sumNext_s;
            end
            if (nextState_s == ST_ERROR && state_r != ST_ERROR) begin
               errCode_r <= errNext_s;
            end
            if (state_r == ST_WRITE) begin
               memAddr_r <= memAddr_r + 16'd1;
            end
         end
         if (accept_s) begin
            case (state_r)
               ST_CNT_HI: countHi_r   <= i_rxData;
               ST_CNT_LO: wordCount_r <= count16_s;
               ST_B0:     instrHi_r   <= i_rxData[6:7];
               ST_B1:     instrMid_r  <= i_rxData;
               ST_B2:     memData_r   <= {instrHi_r, instrMid_r, i_rxData};
               default:   countHi_r   <= countHi_r;
            endcase
         end
      end
   end

   assign o_rxReady = rxReady_s;
   assign o_memAddr = memAddr_r;
   assign o_memData = memData_r;
   assign o_memWE   = memWE_r;
   assign o_cpuHold = cpuHold_r;
   assign o_busy    = busy_r;
   assign o_done    = done_r;
   assign o_errCode = errCode_r;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the program-memory instruction port: the CPU fetches 18-bit instructions by address; this block fills that memory.
- Accepts a framed byte stream from a host byte source over a valid/ready handshake, then assembles 18-bit instruction words.
- Writes the words sequentially into program RAM, verifies a checksum, and holds the CPU stopped until a good image is loaded.

Parameters:
- MAX_WORDS, 1024: largest accepted word count; program RAM depth.
- TIMEOUT_CYCLES, 100000: maximum idle cycles between bytes while loading before aborting.

Ports:
- i_clock, input, 1: system clock; all state changes on the rising edge.
- i_reset, input, 1: asynchronous, active-high reset.
- i_start, input, 1: one-cycle pulse that begins a load session; honoured only in IDLE, DONE or ERROR.
- i_rxData, input, [0:7]: incoming byte; bit 0 is the MSB.
- i_rxValid, input, 1: i_rxData is valid.
- o_rxReady, output, 1: loader can accept a byte. A byte transfers on a rising edge where i_rxValid and o_rxReady are both 1.
- o_memAddr, output, [0:15]: program RAM write address.
- o_memData, output, [0:17]: instruction word to write.
- o_memWE, output, 1: one-cycle write strobe.
- o_cpuHold, output, 1: keeps the CPU stopped and instruction pointer cleared while 1.
- o_busy, output, 1: a session is in progress.
- o_done, output, 1: last session succeeded.
- o_errCode, output, [0:2]: 000 none, 001 checksum, 010 length, 011 format, 100 timeout.

Behaviour:
- Reset (asynchronous; any state, including mid-load):
  - state=IDLE; o_cpuHold=1; o_rxReady=0; o_memWE=0; o_memAddr=0; o_memData=0; o_busy=0; o_done=0; o_errCode=000.
  - Internal count, checksum and timer are all cleared.
- States: IDLE, CNT_HI, CNT_LO, B0, B1, B2, WRITE, CSUM, DONE, ERROR.
- IDLE/DONE/ERROR:
  - o_rxReady=0.
  - i_start -> CNT_HI; clears o_memAddr, checksum, o_done and o_errCode; sets o_busy=1 and o_cpuHold=1.
- CNT_HI, CNT_LO: receive the 16-bit word count, big-endian.
  - On the CNT_LO accept: count>MAX_WORDS -> ERROR with code 010.
  - count==0 -> CSUM; otherwise -> B0.
- B0, B1, B2: receive one instruction word as three bytes.
  - B0 byte: bits [0:5] must be 0, else ERROR with code 011. Bits [6:7] become instr[0:1].
  - B1 byte becomes instr[2:9].
  - B2 byte becomes instr[10:17]; next state is WRITE.
- WRITE (exactly 1 cycle):
  - o_rxReady=0; o_memWE=1; o_memData holds the assembled word; o_memAddr holds the current index.
  - Next cycle: o_memAddr increments. If this was the last word -> CSUM, else -> B0.
  - o_memAddr never exceeds MAX_WORDS-1 while o_memWE=1.
- Checksum: an 8-bit modulo-256 running sum of every accepted byte, including the count bytes and the checksum byte itself.
- CSUM: accept one byte. If the sum including it is 0x00 -> DONE, else ERROR with code 001.
- DONE: o_cpuHold=0; o_done=1; o_busy=0.
- ERROR: o_cpuHold stays 1; o_busy=0; o_errCode latched.
  - Words already written are not erased.
- Timeout:
  - The counter runs in CNT_HI..CSUM, except during WRITE.
  - It clears on every accepted byte.
  - Reaching TIMEOUT_CYCLES -> ERROR with code 100.
- Simultaneous events:
  - Timeout expiry and a byte accept in the same cycle: the accept wins.
  - i_start while busy is ignored.
  - i_rxValid while o_rxReady=0 is ignored; no byte is consumed.
- Latency: o_memWE rises 1 cycle after the B2 accept.
- o_rxReady is combinational from state only, with no dependency on i_rxValid.

Decomposition:
- prog_loader_pkg holds:
  - the state enum;
  - the error-code constants (ERR_NONE, ERR_CSUM, ERR_LEN, ERR_FMT, ERR_TIMEOUT);
  - INSTR_W=18 and BYTE_W=8.
- One sub-module, loader_timer: a clearable, enabled down-counter with an expired flag, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Nominal load: start, then bytes 00 02 03 FF FF 00 00 01 FC.
  - Required: two writes, addr 0 data 0x3FFFF and addr 1 data 0x00001.
  - Then o_done=1, o_cpuHold=0, o_errCode=000.
- Empty image: start, then bytes 00 00 00.
  - Required: no o_memWE, DONE, o_cpuHold=0.
- Bad checksum: nominal stream with the last byte FD.
  - Required: two writes still occur; then ERROR, o_errCode=001, o_cpuHold=1.
- Length and format errors:
  - Count bytes 04 01 (1025) -> ERROR 010 after the second byte, no writes.
  - Separately, count 00 01 followed by B0=0x07 -> ERROR 011, no writes.
- Timeout and backpressure:
  - Stall i_rxValid for TIMEOUT_CYCLES after the count bytes -> ERROR 100.
  - Hold i_rxValid high across WRITE -> no byte lost, addresses consecutive.
- Reset mid-load: assert i_reset during B1 of word 0.
  - Required: all outputs take reset values immediately.
  - A following i_start plus the nominal stream must succeed.
